// File: rtl/packet_scheduler_pkg.sv
// Shared types and island timing constants for the HDMI data-island packet scheduler.
package my_types;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      LEAD_GUARD,
      PACKET,
      TRAIL_GUARD
   } PktSchedState;

   localparam int PREAMBLE_LEN    = 8;
   localparam int GUARD_LEN       = 2;
   localparam int PACKET_LEN      = 32;
   localparam int ISLAND_OVERHEAD = 12;
   localparam int MIN_WINDOW      = ISLAND_OVERHEAD + PACKET_LEN;

endpackage

// File: rtl/packet_scheduler_arbiter.sv
// Packet-slot arbiter: one-hot grant from level requests.
// PKT_SCHED_RR_EN selects round-robin from pointer; otherwise fixed priority (index 0 wins).
module pkt_arbiter
   import my_types::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
`ifdef PKT_SCHED_RR_EN
   input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] pointer,
`endif
   output logic [NUM_REQ-1:0] grant,
   output logic               valid
);

`ifdef PKT_SCHED_RR_EN
   logic [NUM_REQ-1:0] masked;
   logic [NUM_REQ-1:0] pick;

   // Requests at or above the pointer win first; otherwise wrap to the lowest requester.
   always_comb begin
      masked = req & ({NUM_REQ{1'b1}} << pointer);
      pick   = (|masked) ? masked : req;
      grant  = pick & (~pick + NUM_REQ'(1));
      valid  = |req;
   end
`else
   always_comb begin
      grant = req & (~req + NUM_REQ'(1));
      valid = |req;
   end
`endif

endmodule

// File: rtl/packet_scheduler.sv
// HDMI data-island scheduler: preamble, guards, 32-cycle packet slots and per-slot source grant.
// Define PKT_SCHED_RR_EN for round-robin arbitration; default build is fixed priority.
module packet_scheduler
   import my_types::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MAX_PKTS = 18
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               island_open,
   input  logic [11:0]        window_cycles,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               pkt_start,
   output logic               null_pkt,
   output logic [4:0]         pkt_cycle,
   output logic               data_preamble,
   output logic               data_guard,
   output logic               data_period,
   output logic               busy
);

   PktSchedState       state_reg, state_next;
   logic [4:0]         cnt_reg, cnt_next;
   logic [4:0]         slots_reg, slots_next;
   logic [4:0]         used_reg, used_next;
   logic [NUM_REQ-1:0] grant_reg, grant_next;
   logic               null_reg, null_next;
   logic [NUM_REQ-1:0] arb_grant;
   logic               arb_valid;
   logic               pkt_go;
   logic [11:0]        budget;
   logic [4:0]         slots_calc;
   logic               start_island;

`ifdef PKT_SCHED_RR_EN
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] grant_idx;

   pkt_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
      .req     (req),
      .pointer (ptr_reg),
      .grant   (arb_grant),
      .valid   (arb_valid)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) grant_idx = PTR_W'(i);
      end
   end

   // Null packets leave the pointer where it is.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_reg <= '0;
      end else if (pkt_go && arb_valid) begin
         ptr_reg <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
   end
`else
   pkt_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
      .req   (req),
      .grant (arb_grant),
      .valid (arb_valid)
   );
`endif

   always_comb begin
      budget       = (window_cycles - 12'(ISLAND_OVERHEAD)) >> $clog2(PACKET_LEN);
      slots_calc   = 5'((budget > 12'(MAX_PKTS)) ? 12'(MAX_PKTS) : budget);
      start_island = island_open && (window_cycles >= 12'(MIN_WINDOW))
                     && (slots_calc != '0) && (req != '0);
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 5'd1;
      slots_next = slots_reg;
      used_next  = used_reg;
      grant_next = '0;
      null_next  = null_reg;
      pkt_go     = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next  = '0;
            null_next = 1'b0;
            if (start_island) begin
               state_next = PREAMBLE;
               slots_next = slots_calc;
               used_next  = '0;
            end
         end
         PREAMBLE: begin
            if (cnt_reg == 5'(PREAMBLE_LEN - 1)) begin
               cnt_next   = '0;
               state_next = LEAD_GUARD;
            end
         end
         LEAD_GUARD: begin
            if (cnt_reg == 5'(GUARD_LEN - 1)) begin
               cnt_next   = '0;
               state_next = PACKET;
               pkt_go     = 1'b1;
            end
         end
         PACKET: begin
            // used_reg already counts the packet now ending.
            if (cnt_reg == 5'(PACKET_LEN - 1)) begin
               cnt_next = '0;
               if ((used_reg >= slots_reg) || (req == '0)) begin
                  state_next = TRAIL_GUARD;
               end else begin
                  pkt_go = 1'b1;
               end
            end
         end
         TRAIL_GUARD: begin
            if (cnt_reg == 5'(GUARD_LEN - 1)) begin
               cnt_next   = '0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      if (pkt_go) begin
         grant_next = arb_grant;
         null_next  = !arb_valid;
         used_next  = used_reg + 5'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         slots_reg <= '0;
         used_reg  <= '0;
         grant_reg <= '0;
         null_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         slots_reg <= slots_next;
         used_reg  <= used_next;
         grant_reg <= grant_next;
         null_reg  <= null_next;
      end
   end

   always_comb begin
      data_preamble = (state_reg == PREAMBLE);
      data_guard    = (state_reg == LEAD_GUARD) || (state_reg == TRAIL_GUARD);
      data_period   = (state_reg == PACKET);
      busy          = data_preamble || data_guard || data_period;
      pkt_start     = data_period && (cnt_reg == '0);
      pkt_cycle     = data_period ? cnt_reg : '0;
      null_pkt      = data_period && null_reg;
      grant         = grant_reg;
   end

endmodule
